// File: rtl/sm_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial
// sign-magnitude adder.
interface sm_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  modport master (
    output in_valid,
    output num1,
    output num2,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  num1,
    input  num2,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output ovf
  );
endinterface

// File: rtl/sm_serial_adder.sv
// Bit-serial sign-magnitude adder: one magnitude bit
// per clock, result and overflow held until accepted.
module sm_serial_adder #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  sm_serial_adder_if.slave bus
);
  localparam int MW = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE, CMP, ADD, DONE
  } state_t;

  state_t           state_q;
  logic [MW-1:0]    a_q;
  logic [MW-1:0]    b_q;
  logic [MW-1:0]    res_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             sub_q;
  logic             s1_q;
  logic             s2_q;
  logic             sgn_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;

  logic          bit_d;
  logic          c_d;
  logic [MW-1:0] mag_d;
  logic          ovf_d;
  logic          sgn_d;
  logic          swap_d;

  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ c_q;
    if (sub_q)
      c_d = (~a_q[0] & b_q[0])
          | (~(a_q[0] ^ b_q[0]) & c_q);
    else
      c_d = (a_q[0] & b_q[0])
          | (c_q & (a_q[0] ^ b_q[0]));
    mag_d  = {bit_d, res_q[MW-1:1]};
    ovf_d  = ~sub_q & c_d;
    // zero magnitude without overflow is always +0
    sgn_d  = sgn_q & (ovf_d | (|mag_d));
    swap_d = (s1_q != s2_q) && (b_q > a_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      sub_q       <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.num1[MW-1:0];
            b_q        <= bus.num2[MW-1:0];
            s1_q       <= bus.num1[MW]
                        & (|bus.num1[MW-1:0]);
            s2_q       <= bus.num2[MW]
                        & (|bus.num2[MW-1:0]);
            cnt_q      <= '0;
            c_q        <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CMP;
          end
        end
        CMP: begin
          sub_q <= (s1_q != s2_q);
          if (swap_d) begin
            a_q   <= b_q;
            b_q   <= a_q;
            sgn_q <= s2_q;
          end else begin
            sgn_q <= s1_q;
          end
          state_q <= ADD;
        end
        ADD: begin
          res_q <= mag_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(MW - 1)) begin
            sum_q       <= {sgn_d, mag_d};
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/sm_serial_adder.md
# sm_serial_adder

Bit-serial sign-magnitude adder: accepts two WIDTH-bit sign-magnitude operands over a valid/ready handshake and returns their sum, also in sign-magnitude, with an overflow flag. It is the additive counterpart of the team's combinational sign-magnitude subtractor. It trades latency for area, using one magnitude bit per clock, and sits in the arithmetic datapath behind an operand-issue stage.

## Interface
- WIDTH, 32: total operand width; bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude (must be ≥ 3).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands present on num1/num2.
- in_ready  output  1  block can accept operands; registered.
- num1  input  WIDTH  first operand, sign-magnitude.
- num2  input  WIDTH  second operand, sign-magnitude.
- out_valid  output  1  sum/ovf valid; registered.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, sign-magnitude; registered.
- ovf  output  1  magnitude overflow on same-sign add; registered.

## Operation
- States: IDLE, CMP, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch num1/num2, clear the bit counter and carry/borrow flop, then go to CMP.
- CMP, 1 cycle:
  - If signs are equal, op=add and result sign=sign of num1.
  - If signs differ, op=subtract. The larger magnitude becomes A and the smaller becomes B. Result sign is the sign of the larger-magnitude operand; equal magnitudes give sign 0.
  - Go to ADD.
- ADD, WIDTH-1 cycles:
  - Each cycle, process the LSB of the A/B shift registers with a full adder (op=add) or full subtractor A−B (op=subtract).
  - Shift the result bit into the result shift register MSB-side, then shift A/B right.
  - Update the carry/borrow flop.
  - After bit WIDTH-2, go to DONE.
- DONE:
  - sum={sign, magnitude}.
  - ovf = final carry when op=add, else 0.
  - out_valid=1.
  - On out_ready, go to IDLE and drop out_valid.
- Width and arithmetic rules:
  - Magnitude is WIDTH-1 bits. On overflow, the magnitude wraps (carry discarded) and the sign stays equal to the operand sign.
  - Subtraction never overflows. The borrow out is always 0 because A ≥ B.
- Zero rules:
  - A zero magnitude with ovf=0 always produces sign 0 (no −0 output).
  - −0 inputs are treated as +0.
- in_valid is ignored outside IDLE; in_ready=0 in CMP, ADD and DONE.
- sum and ovf are held stable from the out_valid rise until the handshake completes, and keep their value afterwards until the next DONE.
- Reset (rst_n=0 at a rising edge), taking effect at that edge from any state:
  - State goes to IDLE, with in_ready=1, out_valid=0, sum=0, ovf=0.
  - Internal shift registers, counter and carry are cleared.
  - An in-flight operation is discarded and produces no out_valid.

## Timing
- The accepting edge is the edge where in_valid&&in_ready is sampled high.
- out_valid rises after the WIDTH-th rising edge following the accepting edge. For WIDTH=32, that is 32 edges (1 CMP + 31 ADD).
- A result is transferred on the edge where out_valid&&out_ready are both high. out_ready high on the first DONE cycle gives a one-cycle out_valid pulse.
- in_ready rises the cycle after the output transfer. The earliest next accept is that edge, so minimum issue interval is WIDTH+2 cycles.
- Reset dominates all handshakes at the same edge.

## Test plan
- Same-sign add:
  - num1=0x00000005, num2=0x00000003 → sum=0x00000008, ovf=0.
  - out_valid high exactly 32 edges after accept.
- Mixed signs:
  - 0x00000005 + 0x80000007 → 0x80000002.
  - 0x80000064 + 0x0000000A → 0x8000005A.
  - 0x0000000A + 0x80000003 → 0x00000007.
  - All with ovf=0.
- Zero cases:
  - 0x80000009 + 0x00000009 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x00000000.
  - 0x00000000 + 0x80000004 → 0x80000004.
- Overflow:
  - 0x7FFFFFFF + 0x00000001 → sum=0x00000000, ovf=1.
  - 0xFFFFFFFF + 0x80000002 → sum=0x80000001, ovf=1.
  - Next op 0x00000001 + 0x00000001 → 0x00000002, ovf=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid, sum and ovf stable, in_ready=0.
  - in_valid pulses with other operands are ignored.
  - Raise out_ready → transfer, then in_ready=1 the following cycle.
- Reset mid-operation:
  - Drop rst_n for one edge on the 10th ADD cycle of 0x00000123 + 0x00000456.
  - After that edge: in_ready=1, out_valid=0, sum=0, ovf=0, and no spurious result.
  - Then issue 0x00000123 + 0x00000456 → 0x00000579 after 32 edges.
